// File: rtl/seq_div_40by8.sv
// Sequential restoring divider, 40-bit dividend by 8-bit divisor, start/busy/done handshake.
// Define DIV_RADIX4_EN to retire two quotient bits per clock instead of one.
module seq_div_40by8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [39:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [39:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  r_state;
  logic [7:0]  r_part;
  logic [39:0] r_q;
  logic [7:0]  r_d;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_dbz;
  logic [39:0] r_quot;
  logic [7:0]  r_rem;

  logic [7:0]  w_partNext;
  logic [39:0] w_qNext;
  logic [5:0]  w_steps;

  // The partial remainder always ends a step below D, so 8 bits hold it and
  // the modulo-256 difference equals the true difference.
`ifdef DIV_RADIX4_EN
  logic [9:0]  w_t;
  logic [9:0]  w_d1;
  logic [9:0]  w_d2;
  logic [9:0]  w_d3;
  logic [1:0]  w_qBits;
  logic [7:0]  w_sub;

  assign w_steps = 6'd20;
  assign w_t     = {r_part, r_q[39:38]};
  assign w_d1    = {2'b00, r_d};
  assign w_d2    = {1'b0, r_d, 1'b0};
  assign w_d3    = w_d1 + w_d2;

  always_comb begin
    w_qBits = 2'd0;
    w_sub   = 8'd0;
    if (w_t >= w_d3) begin
      w_qBits = 2'd3;
      w_sub   = w_d3[7:0];
    end else if (w_t >= w_d2) begin
      w_qBits = 2'd2;
      w_sub   = w_d2[7:0];
    end else if (w_t >= w_d1) begin
      w_qBits = 2'd1;
      w_sub   = w_d1[7:0];
    end
  end

  assign w_partNext = w_t[7:0] - w_sub;
  assign w_qNext    = {r_q[37:0], w_qBits};
`else
  logic [8:0]  w_t;
  logic        w_ge;

  assign w_steps    = 6'd40;
  assign w_t        = {r_part, r_q[39]};
  assign w_ge       = (w_t >= {1'b0, r_d});
  assign w_partNext = w_ge ? (w_t[7:0] - r_d) : w_t[7:0];
  assign w_qNext    = {r_q[38:0], w_ge};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_part  <= 8'd0;
      r_q     <= 40'd0;
      r_d     <= 8'd0;
      r_cnt   <= 6'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_quot  <= 40'd0;
      r_rem   <= 8'd0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          if (divisor != 8'd0) begin
            r_q     <= dividend;
            r_d     <= divisor;
            r_part  <= 8'd0;
            r_cnt   <= w_steps;
            r_busy  <= 1'b1;
            r_dbz   <= 1'b0;
            r_state <= RUN;
          end else begin
            // Divide-by-zero completes at once without entering RUN.
            r_done <= 1'b1;
            r_dbz  <= 1'b1;
            r_quot <= 40'hFF_FFFF_FFFF;
            r_rem  <= dividend[7:0];
          end
        end
      end else begin
        r_part <= w_partNext;
        r_q    <= w_qNext;
        r_cnt  <= r_cnt - 6'd1;
        if (r_cnt == 6'd1) begin
          r_quot  <= w_qNext;
          r_rem   <= w_partNext;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_div_40by8.sv
// Self-checking bench for seq_div_40by8: arithmetic reference model, per-cycle compare,
// directed cases with literal results, then randomized operations.
module tb_seq_div_40by8;

`ifdef DIV_RADIX4_EN
  localparam int LAT = 20;
`else
  localparam int LAT = 40;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [39:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [39:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;
  logic checkEn = 1'b0;

  // Reference model state: results derived with / and %, latency as a countdown.
  logic        mBusy = 1'b0;
  logic        mDone = 1'b0;
  logic        mDbz = 1'b0;
  logic [39:0] mQuot = 40'd0;
  logic [7:0]  mRem = 8'd0;
  logic [39:0] pendQuot = 40'd0;
  logic [7:0]  pendRem = 8'd0;
  int          mCount = 0;

  seq_div_40by8 dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model advances on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    if (rst) begin
      mBusy  = 1'b0;
      mDone  = 1'b0;
      mDbz   = 1'b0;
      mQuot  = 40'd0;
      mRem   = 8'd0;
      mCount = 0;
    end else begin
      mDone = 1'b0;
      if (mCount > 0) begin
        mCount--;
        if (mCount == 0) begin
          mDone = 1'b1;
          mBusy = 1'b0;
          mQuot = pendQuot;
          mRem  = pendRem;
        end
      end else if (start) begin
        if (divisor == 8'd0) begin
          mDone = 1'b1;
          mDbz  = 1'b1;
          mQuot = 40'hFF_FFFF_FFFF;
          mRem  = dividend[7:0];
        end else begin
          pendQuot = dividend / {32'd0, divisor};
          pendRem  = 8'(dividend % {32'd0, divisor});
          mCount   = LAT;
          mBusy    = 1'b1;
          mDbz     = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", 64'(busy), 64'(mBusy));
      checkOutput("done", 64'(done), 64'(mDone));
      checkOutput("div_by_zero", 64'(div_by_zero), 64'(mDbz));
      if (!mBusy) begin
        checkOutput("quotient", 64'(quotient), 64'(mQuot));
        checkOutput("remainder", 64'(remainder), 64'(mRem));
      end
    end
  end

  // Present one start at the current negedge, optionally re-pulse start during RUN,
  // and return at the negedge where done is seen (cycles counted from E0).
  task automatic applyStimulus(input logic [39:0] dvd, input logic [7:0] dvs,
                               input int glitchAt, output int cycles);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < LAT + 5) begin
      start = (cycles == glitchAt) ? 1'b1 : 1'b0;
      if (cycles == glitchAt) begin
        dividend = 40'd50;
        divisor  = 8'd3;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL doneTimeout: no done within %0d cycles for %h / %h", cycles, dvd, dvs);
    end
  endtask

  initial begin
    int cyc;
    logic [39:0] prod;
    logic [39:0] dvd;
    logic [7:0]  dvs;
    logic [47:0] recon;
    bit sawDone;

    rst = 1'b1;
    start = 1'b0;
    dividend = 40'd0;
    divisor = 8'd0;
    @(posedge clk);
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetQuot", 64'(quotient), 64'd0);
    checkOutput("resetDbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] max / max");
    applyStimulus(40'hFF_FFFF_FFFF, 8'hFF, -1, cyc);
    checkOutput("maxLatency", 64'(cyc), 64'(LAT + 1));
    checkOutput("maxQuot", 64'(quotient), 64'h01_0101_0101);
    checkOutput("maxRem", 64'(remainder), 64'd0);
    checkOutput("maxDbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    checkOutput("doneWidth", 64'(done), 64'd0);

    $display("[TB] 1000 / 7 with start during RUN");
    applyStimulus(40'd1000, 8'd7, 5, cyc);
    checkOutput("ignLatency", 64'(cyc), 64'(LAT + 1));
    checkOutput("ignQuot", 64'(quotient), 64'd142);
    checkOutput("ignRem", 64'(remainder), 64'd6);
    @(negedge clk);

    $display("[TB] divide by zero");
    applyStimulus(40'h12_3456_789A, 8'd0, -1, cyc);
    checkOutput("dbzLatency", 64'(cyc), 64'd1);
    checkOutput("dbzFlag", 64'(div_by_zero), 64'd1);
    checkOutput("dbzQuot", 64'(quotient), 64'hFF_FFFF_FFFF);
    checkOutput("dbzRem", 64'(remainder), 64'h9A);
    checkOutput("dbzBusy", 64'(busy), 64'd0);
    @(negedge clk);

    $display("[TB] multiplier round trip");
    prod = 40'(32'hDEADBEEF) * 40'(8'h9C);
    applyStimulus(prod, 8'h9C, -1, cyc);
    checkOutput("rtQuot", 64'(quotient), 64'h00_DEAD_BEEF);
    checkOutput("rtRem", 64'(remainder), 64'd0);
    @(negedge clk);

    $display("[TB] 5 / 9 then back-to-back 200 / 10");
    applyStimulus(40'd5, 8'd9, -1, cyc);
    checkOutput("smallQuot", 64'(quotient), 64'd0);
    checkOutput("smallRem", 64'(remainder), 64'd5);
    applyStimulus(40'd200, 8'd10, -1, cyc);
    checkOutput("b2bLatency", 64'(cyc), 64'(LAT + 1));
    checkOutput("b2bQuot", 64'(quotient), 64'd20);
    checkOutput("b2bRem", 64'(remainder), 64'd0);
    @(negedge clk);

    $display("[TB] reset mid-operation");
    dividend = 40'd12345;
    divisor = 8'd13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRstBusy", 64'(busy), 64'd0);
    checkOutput("midRstQuot", 64'(quotient), 64'd0);
    checkOutput("midRstRem", 64'(remainder), 64'd0);
    sawDone = 1'b0;
    repeat (LAT + 3) begin
      @(negedge clk);
      if (done === 1'b1) sawDone = 1'b1;
    end
    checkOutput("midRstNoDone", 64'(sawDone), 64'd0);
    applyStimulus(40'd12345, 8'd13, -1, cyc);
    checkOutput("afterRstQuot", 64'(quotient), 64'd949);
    checkOutput("afterRstRem", 64'(remainder), 64'd8);
    @(negedge clk);

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      dvd = {8'($urandom), 32'($urandom)};
      dvs = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom_range(255, 1));
      applyStimulus(dvd, dvs, ($urandom_range(3) == 0) ? 7 : -1, cyc);
      if (dvs != 8'd0) begin
        recon = 48'(quotient) * 48'(dvs) + 48'(remainder);
        checkOutput("invariant", 64'(recon), 64'(dvd));
        checkOutput("remLtDiv", 64'(remainder < dvs), 64'd1);
      end
      repeat ($urandom_range(2)) @(negedge clk);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
